// File: rtl/i2s_serializer.sv
// i2s_serializer: transmit-side I2S-style serializer and bus master.
// Accepts left/right sample pairs over valid/ready into a one-pair holding
// buffer. The pairs are shifted out MSB-first, left-justified, on SDATA.
// BCK = SCK/BCK_DIV and LRCK = SCK/(BCK_DIV*2*SLOTS_PER_CH) are generated here.
// Optional macro ZERO_ON_UNDERRUN_EN: an underrun frame sends digital silence
// instead of repeating the last transmitted pair.
module i2s_serializer #(
   parameter int DATA_WIDTH   = 24,
   parameter int BCK_DIV      = 8,
   parameter int SLOTS_PER_CH = 24
) (
   input  logic                  SCK,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] left_in,
   input  logic [DATA_WIDTH-1:0] right_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  BCK,
   output logic                  LRCK,
   output logic                  SDATA,
   output logic                  frame_start,
   output logic                  underrun
);

   localparam int FRAME_BITS = 2 * SLOTS_PER_CH;
   localparam int SCK_W      = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
   localparam int BIT_W      = $clog2(FRAME_BITS);
   localparam logic [SCK_W-1:0] SCK_LAST = SCK_W'(BCK_DIV - 1);
   localparam logic [SCK_W-1:0] SCK_HALF = SCK_W'(BCK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(SLOTS_PER_CH);

   // Place each sample at the top of its slot; the remaining slot bits are zero.
   function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [DATA_WIDTH-1:0] l,
                                                        input logic [DATA_WIDTH-1:0] r);
      logic [SLOTS_PER_CH-1:0] l_slot;
      logic [SLOTS_PER_CH-1:0] r_slot;
      l_slot = SLOTS_PER_CH'(l) << (SLOTS_PER_CH - DATA_WIDTH);
      r_slot = SLOTS_PER_CH'(r) << (SLOTS_PER_CH - DATA_WIDTH);
      return {l_slot, r_slot};
   endfunction

   logic [SCK_W-1:0]      sck_cnt_q, sck_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  bck_q, bck_d;
   logic                  lrck_q, lrck_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic                  buf_full_q, buf_full_d;
   logic [DATA_WIDTH-1:0] buf_left_q, buf_left_d;
   logic [DATA_WIDTH-1:0] buf_right_q, buf_right_d;
   logic                  ready_q, ready_d;
   logic                  frame_start_q, frame_start_d;
   logic                  underrun_q, underrun_d;
`ifdef ZERO_ON_UNDERRUN_EN
   // Underrun frames are silent, so the last pair need not be remembered.
`else
   logic [DATA_WIDTH-1:0] last_left_q, last_left_d;
   logic [DATA_WIDTH-1:0] last_right_q, last_right_d;
`endif

   logic wrap;
   logic load;
   logic xfer;

   assign wrap = enable && (sck_cnt_q == SCK_LAST);
   assign load = wrap && (bit_cnt_q == BIT_LAST);
   assign xfer = in_valid && ready_q;

   // Next-state: bit timing, shift/load of the frame, and the holding buffer.
   always_comb begin
      sck_cnt_d     = sck_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      buf_full_d    = buf_full_q;
      buf_left_d    = buf_left_q;
      buf_right_d   = buf_right_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
`ifdef ZERO_ON_UNDERRUN_EN
`else
      last_left_d   = last_left_q;
      last_right_d  = last_right_q;
`endif
      if (!enable) begin
         // Timing and shift path sit in their post-reset state while stopped.
         sck_cnt_d = '0;
         bit_cnt_d = '0;
         shift_d   = '0;
      end else begin
         sck_cnt_d = wrap ? '0 : sck_cnt_q + SCK_W'(1);
         if (wrap) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
         end
         if (load) begin
            frame_start_d = 1'b1;
            if (buf_full_q) begin
               shift_d    = pack_frame(buf_left_q, buf_right_q);
               buf_full_d = 1'b0;
`ifdef ZERO_ON_UNDERRUN_EN
`else
               last_left_d  = buf_left_q;
               last_right_d = buf_right_q;
`endif
            end else begin
               underrun_d = 1'b1;
`ifdef ZERO_ON_UNDERRUN_EN
               shift_d = '0;
`else
               shift_d = pack_frame(last_left_q, last_right_q);
`endif
            end
         end else if (wrap) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
         end
      end
      // A transfer is only possible with the buffer empty, so it never
      // collides with a buffer-to-shift load; a same-cycle pair waits a frame.
      if (xfer) begin
         buf_full_d  = 1'b1;
         buf_left_d  = left_in;
         buf_right_d = right_in;
      end
      ready_d = !buf_full_d;
      bck_d   = (sck_cnt_d >= SCK_HALF);
      lrck_d  = (bit_cnt_d < BIT_HALF);
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge SCK) begin
      if (!reset_n) begin
         sck_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         bck_q         <= 1'b0;
         lrck_q        <= 1'b1;
         shift_q       <= '0;
         buf_full_q    <= 1'b0;
         buf_left_q    <= '0;
         buf_right_q   <= '0;
         ready_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
`ifdef ZERO_ON_UNDERRUN_EN
`else
         last_left_q   <= '0;
         last_right_q  <= '0;
`endif
      end else begin
         sck_cnt_q     <= sck_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         bck_q         <= bck_d;
         lrck_q        <= lrck_d;
         shift_q       <= shift_d;
         buf_full_q    <= buf_full_d;
         buf_left_q    <= buf_left_d;
         buf_right_q   <= buf_right_d;
         ready_q       <= ready_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
`ifdef ZERO_ON_UNDERRUN_EN
`else
         last_left_q   <= last_left_d;
         last_right_q  <= last_right_d;
`endif
      end
   end

   assign in_ready    = ready_q;
   assign BCK         = bck_q;
   assign LRCK        = lrck_q;
   assign SDATA       = shift_q[FRAME_BITS-1];
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_serializer.sv
// Directed testbench for i2s_serializer (default parameters).
// Honours ZERO_ON_UNDERRUN_EN for the expected contents of underrun frames.
module tb_i2s_serializer;

   logic        SCK = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [23:0] left_in = '0;
   logic [23:0] right_in = '0;
   logic        in_valid = 1'b0;
   logic        in_ready, BCK, LRCK, SDATA, frame_start, underrun;

   int pass_cnt = 0;
   int total_cnt = 0;

   i2s_serializer dut (
      .SCK(SCK), .reset_n(reset_n), .enable(enable),
      .left_in(left_in), .right_in(right_in), .in_valid(in_valid),
      .in_ready(in_ready), .BCK(BCK), .LRCK(LRCK), .SDATA(SDATA),
      .frame_start(frame_start), .underrun(underrun)
   );

   always #5 SCK = ~SCK;

   // Offer one pair; called at a negedge, returns at a negedge after the transfer.
   task automatic send(input logic [23:0] l, input logic [23:0] r, output logic ok);
      ok = 1'b0;
      left_in = l;
      right_in = r;
      in_valid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (in_ready === 1'b1) begin
            @(negedge SCK);
            ok = 1'b1;
            break;
         end
         @(negedge SCK);
      end
      in_valid = 1'b0;
   endtask

   // Wait for the next frame_start, then record SDATA/LRCK on 48 BCK rising edges.
   task automatic capture_frame(output logic [47:0] bits, output logic [47:0] lr,
                                output logic uf, output logic fs_one,
                                output int ones_before, output logic ok);
      logic prev;
      int   n;
      logic found;
      bits = '0; lr = '0; uf = 1'b0; fs_one = 1'b0; ones_before = 0; ok = 1'b0;
      found = 1'b0; n = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge SCK);
         if (frame_start === 1'b1) begin
            found = 1'b1;
            break;
         end
         if (SDATA === 1'b1) ones_before++;
      end
      if (!found) return;
      uf = underrun;
      prev = BCK;
      for (int c = 0; c < 400 && n < 48; c++) begin
         @(negedge SCK);
         if (c == 0) fs_one = (frame_start === 1'b0);
         if (BCK === 1'b1 && prev === 1'b0) begin
            bits = {bits[46:0], SDATA};
            lr = {lr[46:0], LRCK};
            n++;
         end
         prev = BCK;
      end
      ok = (n == 48);
   endtask

   task automatic test_reset;
      logic prev;
      int   cnt;
      reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0;
      repeat (5) @(negedge SCK);
      total_cnt++; if (BCK !== 1'b0) $display("FAIL reset_bck: got %b want 0", BCK); else pass_cnt++;
      total_cnt++; if (LRCK !== 1'b1) $display("FAIL reset_lrck: got %b want 1", LRCK); else pass_cnt++;
      total_cnt++; if (SDATA !== 1'b0) $display("FAIL reset_sdata: got %b want 0", SDATA); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", in_ready); else pass_cnt++;
      total_cnt++; if ({frame_start, underrun} !== 2'b00)
         $display("FAIL reset_pulses: got %b want 00", {frame_start, underrun}); else pass_cnt++;
      reset_n = 1'b1;
      @(negedge SCK);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", in_ready); else pass_cnt++;
      // BCK period: find a rising edge, then count SCK cycles to the next one.
      prev = BCK;
      for (int i = 0; i < 20; i++) begin
         @(negedge SCK);
         if (BCK === 1'b1 && prev === 1'b0) break;
         prev = BCK;
      end
      cnt = 0; prev = BCK;
      for (int i = 0; i < 20; i++) begin
         @(negedge SCK);
         cnt++;
         if (BCK === 1'b1 && prev === 1'b0) break;
         prev = BCK;
      end
      total_cnt++; if (cnt != 8) $display("FAIL bck_period: got %0d want 8", cnt); else pass_cnt++;
      // LRCK: wait for the fall, then measure the low and high phases.
      for (int i = 0; i < 500; i++) begin
         @(negedge SCK);
         if (LRCK === 1'b0) break;
      end
      cnt = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge SCK);
         cnt++;
         if (LRCK === 1'b1) break;
      end
      total_cnt++; if (cnt != 192) $display("FAIL lrck_low: got %0d want 192", cnt); else pass_cnt++;
      cnt = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge SCK);
         cnt++;
         if (LRCK === 1'b0) break;
      end
      total_cnt++; if (cnt != 192) $display("FAIL lrck_high: got %0d want 192", cnt); else pass_cnt++;
      $display("test_reset done");
   endtask

   task automatic test_single_pair;
      logic [47:0] bits, lr;
      logic uf, fs_one, ok;
      int ones;
      reset_n = 1'b0; enable = 1'b0;
      repeat (2) @(negedge SCK);
      reset_n = 1'b1;
      @(negedge SCK);
      send(24'hA5A5A5, 24'h3C0F81, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL single_send: got %b want 1", ok); else pass_cnt++;
      repeat (10) @(negedge SCK);
      total_cnt++; if ({BCK, LRCK, in_ready} !== 3'b010)
         $display("FAIL disabled_hold: got bck,lrck,ready=%b want 010", {BCK, LRCK, in_ready}); else pass_cnt++;
      enable = 1'b1;
      capture_frame(bits, lr, uf, fs_one, ones, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL single_capture: timeout"); else pass_cnt++;
      total_cnt++; if (ones != 0) $display("FAIL first_frame_silent: got %0d ones want 0", ones); else pass_cnt++;
      total_cnt++; if (bits !== {24'hA5A5A5, 24'h3C0F81})
         $display("FAIL single_bits: got %h want a5a5a53c0f81", bits); else pass_cnt++;
      total_cnt++; if (lr !== {24'hFFFFFF, 24'h000000})
         $display("FAIL single_lrck: got %h want ffffff000000", lr); else pass_cnt++;
      total_cnt++; if (uf !== 1'b0) $display("FAIL single_underrun: got %b want 0", uf); else pass_cnt++;
      total_cnt++; if (fs_one !== 1'b1) $display("FAIL single_fs_width: pulse longer than one SCK"); else pass_cnt++;
      $display("test_single_pair done: bits=%h", bits);
   endtask

   task automatic test_underrun;
      logic [47:0] bits, lr, exp_rep;
      logic uf, fs_one, ok;
      int ones;
`ifdef ZERO_ON_UNDERRUN_EN
      exp_rep = 48'h0;
`else
      exp_rep = {24'h7FFFFF, 24'h800000};
`endif
      send(24'h7FFFFF, 24'h800000, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL underrun_send: got %b want 1", ok); else pass_cnt++;
      capture_frame(bits, lr, uf, fs_one, ones, ok);
      total_cnt++; if (ok !== 1'b1 || bits !== {24'h7FFFFF, 24'h800000} || uf !== 1'b0)
         $display("FAIL underrun_pre: got ok=%b bits=%h uf=%b want 1 7fffff800000 0", ok, bits, uf); else pass_cnt++;
      capture_frame(bits, lr, uf, fs_one, ones, ok);
      total_cnt++; if (uf !== 1'b1) $display("FAIL underrun_pulse: got %b want 1", uf); else pass_cnt++;
      total_cnt++; if (ok !== 1'b1 || bits !== exp_rep)
         $display("FAIL underrun_bits: got ok=%b bits=%h want 1 %h", ok, bits, exp_rep); else pass_cnt++;
      $display("test_underrun done: bits=%h", bits);
   endtask

   task automatic test_race;
      logic [47:0] bits, lr;
      logic uf, fs_one, ok;
      int ones;
      // The last capture ended at the BCK rise of bit 47; three cycles on is the load cycle.
      repeat (3) @(negedge SCK);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL race_ready_before: got %b want 1", in_ready); else pass_cnt++;
      left_in = 24'h123456; right_in = 24'hFEDCBA; in_valid = 1'b1;
      @(negedge SCK);
      in_valid = 1'b0;
      total_cnt++; if ({frame_start, underrun} !== 2'b11)
         $display("FAIL race_underrun: got fs,ur=%b want 11", {frame_start, underrun}); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL race_buffered: got ready=%b want 0", in_ready); else pass_cnt++;
      capture_frame(bits, lr, uf, fs_one, ones, ok);
      total_cnt++; if (ok !== 1'b1 || bits !== {24'h123456, 24'hFEDCBA} || uf !== 1'b0)
         $display("FAIL race_next_frame: got ok=%b bits=%h uf=%b want 1 123456fedcba 0", ok, bits, uf); else pass_cnt++;
      $display("test_race done: bits=%h", bits);
   endtask

   task automatic test_mid_reset;
      logic [47:0] bits, lr;
      logic uf, fs_one, ok, prev;
      int ones, rises;
      for (int i = 0; i < 20; i++) begin
         @(negedge SCK);
         if (frame_start === 1'b1) break;
      end
      send(24'hDEAD00, 24'h00BEEF, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL midrst_send: got %b want 1", ok); else pass_cnt++;
      // Count BCK rises from bit 0; the 31st rise is bit 30.
      rises = 0; prev = BCK;
      for (int i = 0; i < 400 && rises < 31; i++) begin
         @(negedge SCK);
         if (BCK === 1'b1 && prev === 1'b0) rises++;
         prev = BCK;
      end
      total_cnt++; if (LRCK !== 1'b0) $display("FAIL midrst_lrck_before: got %b want 0", LRCK); else pass_cnt++;
      reset_n = 1'b0;
      @(negedge SCK);
      total_cnt++; if ({BCK, LRCK, SDATA, in_ready, frame_start, underrun} !== 6'b010000)
         $display("FAIL midrst_outputs: got %b want 010000",
                  {BCK, LRCK, SDATA, in_ready, frame_start, underrun}); else pass_cnt++;
      repeat (2) @(negedge SCK);
      reset_n = 1'b1; enable = 1'b1;
      capture_frame(bits, lr, uf, fs_one, ones, ok);
      total_cnt++; if (ok !== 1'b1 || bits !== 48'h0 || ones != 0)
         $display("FAIL midrst_discard: got ok=%b bits=%h ones=%0d want 1 0 0", ok, bits, ones); else pass_cnt++;
      total_cnt++; if (uf !== 1'b1) $display("FAIL midrst_underrun: got %b want 1", uf); else pass_cnt++;
      $display("test_mid_reset done: bits=%h", bits);
   endtask

   task automatic test_back_to_back;
      logic [47:0] got [0:7];
      logic [47:0] cur;
      logic prev, collecting, pend;
      int k, acc, fs_cnt, ur_cnt, ready_bad, nf, n;
      reset_n = 1'b0; enable = 1'b1;
      repeat (3) @(negedge SCK);
      k = 0; acc = 0; fs_cnt = 0; ur_cnt = 0; ready_bad = 0; nf = 0; n = 0;
      cur = '0; prev = 1'b0; collecting = 1'b0; pend = 1'b0;
      for (int i = 0; i < 8; i++) got[i] = '0;
      left_in = 24'h100000; right_in = 24'h200000; in_valid = 1'b1;
      reset_n = 1'b1;
      for (int c = 0; c < 5 * 384 + 8; c++) begin
         @(negedge SCK);
         if (pend) begin
            k++;
            left_in = 24'h100000 + 24'(k);
            right_in = 24'h200000 + 24'(k);
            pend = 1'b0;
         end
         if (acc > 0 && in_ready !== frame_start) ready_bad++;
         if (in_ready === 1'b1) begin
            acc++;
            pend = 1'b1;
         end
         if (underrun === 1'b1) ur_cnt++;
         if (frame_start === 1'b1) begin
            fs_cnt++;
            if (collecting && n == 48 && nf < 8) begin
               got[nf] = cur;
               nf++;
            end
            collecting = 1'b1; n = 0; cur = '0; prev = BCK;
         end else if (collecting) begin
            if (BCK === 1'b1 && prev === 1'b0) begin
               cur = {cur[46:0], SDATA};
               n++;
            end
            prev = BCK;
         end
      end
      in_valid = 1'b0;
      total_cnt++; if (fs_cnt != 5) $display("FAIL b2b_frames: got %0d want 5", fs_cnt); else pass_cnt++;
      total_cnt++; if (acc != 6) $display("FAIL b2b_accepted: got %0d want 6", acc); else pass_cnt++;
      total_cnt++; if (ready_bad != 0) $display("FAIL b2b_ready_shape: got %0d bad cycles want 0", ready_bad); else pass_cnt++;
      total_cnt++; if (ur_cnt != 0) $display("FAIL b2b_underrun: got %0d want 0", ur_cnt); else pass_cnt++;
      total_cnt++; if (nf != 4) $display("FAIL b2b_complete: got %0d want 4", nf); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (got[i] !== {24'h100000 + 24'(i), 24'h200000 + 24'(i)})
            $display("FAIL b2b_frame%0d: got %h want %h", i, got[i],
                     {24'h100000 + 24'(i), 24'h200000 + 24'(i)});
         else pass_cnt++;
      end
      $display("test_back_to_back done: accepted=%0d frames=%0d", acc, fs_cnt);
   endtask

   initial begin
      test_reset();
      test_single_pair();
      test_underrun();
      test_race();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
